// File: rtl/onchip_ram_sdp_be.sv
// onchip_ram_sdp_be
//   Simple dual-port (1R/1W) single-clock block RAM with byte-lane write
//   enables, selectable same-address read-during-write behaviour, an optional
//   output register stage, read-valid tagging and a zero-fill sequencer.
//
// Parameters
//   ADDR_W  : address width, DEPTH = 2**ADDR_W words
//   DATA_W  : word width, multiple of 8; LANES = DATA_W/8
//   RDW_NEW : 0 = same-address read-during-write returns old word,
//             1 = returns the byte-merged new word
//   OUT_REG : 1 adds an output register; read latency = 1 + OUT_REG
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   re, raddr             : read request / address
//   rdata, rvalid         : read data, valid for the read issued 1+OUT_REG
//                           cycles earlier; rdata holds between reads
//   we, waddr, wdata, wbe : write request / address / data / byte enables
//   clr_start             : pulse to start zero-filling the whole array
//   busy                  : zero-fill in progress; external accesses ignored
//   clr_done              : one-cycle pulse after the last word is cleared
//   wr_drop               : external write discarded because busy
module onchip_ram_sdp_be #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter logic        RDW_NEW = 1'b0,
  parameter logic        OUT_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LANES = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
    $error("onchip_ram_sdp_be: DATA_W must be a non-zero multiple of 8");
  end

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef ONCHIP_RAM_SIM
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Zero-fill sequencer
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_q, clr_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // Counter parks on the last address rather than wrapping.
        if (cnt_q == '1) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign busy     = (state_q == S_CLEAR);
  assign clr_done = clr_done_q;

  logic ext_we;
  logic ext_re;

  assign ext_we  = we & ~busy;
  assign ext_re  = re & ~busy;
  assign wr_drop = we & busy;

  // ---------------------------------------------------------------------------
  // Array write port: shared between the fill sequencer and external writes
  // ---------------------------------------------------------------------------
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_wbe;

  always_comb begin
    mem_we    = ext_we;
    mem_waddr = waddr;
    mem_wdata = wdata;
    mem_wbe   = wbe;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: array read (old-data RDW) plus captured write for forwarding
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_word_q, rd_word_d;
  logic              rvalid1_q, rvalid1_d;
  logic              hit1_q, hit1_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d;
  logic [LANES-1:0]  wbe1_q, wbe1_d;

  always_comb begin
    rd_word_d = rd_word_q;
    hit1_d    = hit1_q;
    wdata1_d  = wdata1_q;
    wbe1_d    = wbe1_q;
    rvalid1_d = ext_re;
    // Stage-1 state only moves on an accepted read so rdata holds otherwise.
    if (ext_re) begin
      rd_word_d = mem[raddr];
      hit1_d    = RDW_NEW & ext_we & (waddr == raddr);
      wdata1_d  = wdata;
      wbe1_d    = wbe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word_q <= '0;
      rvalid1_q <= 1'b0;
      hit1_q    <= 1'b0;
      wdata1_q  <= '0;
      wbe1_q    <= '0;
    end else begin
      rd_word_q <= rd_word_d;
      rvalid1_q <= rvalid1_d;
      hit1_q    <= hit1_d;
      wdata1_q  <= wdata1_d;
      wbe1_q    <= wbe1_d;
    end
  end

  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = rd_word_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (hit1_q && wbe1_q[i]) merged[8*i +: 8] = wdata1_q[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register
  // ---------------------------------------------------------------------------
  if (OUT_REG) begin : g_out_reg
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              rvalid2_q, rvalid2_d;

    always_comb begin
      rdata2_d  = rvalid1_q ? merged : rdata2_q;
      rvalid2_d = rvalid1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata2_q  <= '0;
        rvalid2_q <= 1'b0;
      end else begin
        rdata2_q  <= rdata2_d;
        rvalid2_q <= rvalid2_d;
      end
    end

    assign rdata  = rdata2_q;
    assign rvalid = rvalid2_q;
  end else begin : g_no_out_reg
    assign rdata  = merged;
    assign rvalid = rvalid1_q;
  end

endmodule
